// File: rtl/busca_instrucao.sv
// nRISC instruction fetch stage: PC, request/ack fetch, instruction
// register with opcode and 2-bit register field slices.
module busca_instrucao #(
  parameter int                 LARG_PC    = 8,
  parameter logic [LARG_PC-1:0] PC_INICIAL = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic [LARG_PC-1:0] mem_addr,
  output logic               mem_req,
  input  logic               mem_ack,
  input  logic [7:0]         mem_data,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [LARG_PC-1:0] branch_target,
  output logic [7:0]         instr,
  output logic               instr_valid,
  output logic [LARG_PC-1:0] pc_instr,
  output logic [2:0]         opcode,
  output logic [1:0]         campo_a,
  output logic [1:0]         campo_b
);

  typedef enum logic {
    ESPERA = 1'b0,
    VALIDA = 1'b1
  } estado_t;

  estado_t            state_q, state_d;
  logic [LARG_PC-1:0] pc_q, pc_d;
  logic [LARG_PC-1:0] pc_instr_q, pc_instr_d;
  logic [7:0]         instr_q, instr_d;
  logic               valid_q, valid_d;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_instr_d = pc_instr_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    // a redirect wins over ack and stall alike
    if (branch_taken) begin
      pc_d    = branch_target;
      valid_d = 1'b0;
      state_d = ESPERA;
    end else begin
      unique case (state_q)
        ESPERA: begin
          if (mem_ack) begin
            instr_d    = mem_data;
            pc_instr_d = pc_q;
            pc_d       = pc_q + 1'b1;
            valid_d    = 1'b1;
            state_d    = VALIDA;
          end
        end
        VALIDA: begin
          if (!stall) begin
            valid_d = 1'b0;
            state_d = ESPERA;
          end
        end
        default: state_d = ESPERA;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ESPERA;
      pc_q       <= PC_INICIAL;
      pc_instr_q <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_instr_q <= pc_instr_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign mem_req     = (state_q == ESPERA) && !reset;
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc_instr    = pc_instr_q;
  assign opcode      = instr_q[7:5];
  assign campo_a     = instr_q[4:3];
  assign campo_b     = instr_q[2:1];

endmodule

// File: tb/tb_busca_instrucao.sv
// Scoreboard bench for busca_instrucao: directed fetch scenarios
// followed by randomized traffic against a behavioural model.
module tb_busca_instrucao;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic       stall;
  logic       branch_taken;
  logic [7:0] branch_target;
  logic [7:0] instr;
  logic       instr_valid;
  logic [7:0] pc_instr;
  logic [2:0] opcode;
  logic [1:0] campo_a;
  logic [1:0] campo_b;

  busca_instrucao #(
    .LARG_PC   (8),
    .PC_INICIAL(8'h00)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .mem_addr     (mem_addr),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_data     (mem_data),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc_instr     (pc_instr),
    .opcode       (opcode),
    .campo_a      (campo_a),
    .campo_b      (campo_b)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit       req;
    bit [7:0] addr;
    bit [7:0] ins;
    bit [7:0] pci;
    bit       v;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // behavioural view: "waiting" for memory or "holding" an instruction
  bit       m_wait = 1'b1;
  int       m_pc   = 0;
  int       m_ins  = 0;
  int       m_pci  = 0;
  bit       m_v    = 1'b0;

  task automatic chk(string nm, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic step(bit r, bit ack, bit [7:0] d, bit st, bit br,
                      bit [7:0] tgt);
    exp_t e;
    @(negedge clock);
    reset         = r;
    mem_ack       = ack;
    mem_data      = d;
    stall         = st;
    branch_taken  = br;
    branch_target = tgt;
    if (r) begin
      m_pc = 0; m_ins = 0; m_pci = 0; m_v = 0; m_wait = 1;
    end else if (br) begin
      m_pc = tgt; m_v = 0; m_wait = 1;
    end else if (m_wait) begin
      if (ack) begin
        m_ins = d; m_pci = m_pc; m_pc = (m_pc + 1) % 256;
        m_v = 1; m_wait = 0;
      end
    end else if (!st) begin
      m_v = 0; m_wait = 1;
    end
    e.req  = m_wait && !r;
    e.addr = m_pc[7:0];
    e.ins  = m_ins[7:0];
    e.pci  = m_pci[7:0];
    e.v    = m_v;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mem_req", int'(mem_req), int'(e.req));
        chk("mem_addr", int'(mem_addr), int'(e.addr));
        chk("instr", int'(instr), int'(e.ins));
        chk("instr_valid", int'(instr_valid), int'(e.v));
        chk("pc_instr", int'(pc_instr), int'(e.pci));
        chk("opcode", int'(opcode), int'(e.ins) / 32);
        chk("campo_a", int'(campo_a), (int'(e.ins) / 8) % 4);
        chk("campo_b", int'(campo_b), (int'(e.ins) / 2) % 4);
      end
    end
  end

  initial begin
    reset = 1; mem_ack = 0; mem_data = 0; stall = 0;
    branch_taken = 0; branch_target = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 8'h99, 0, 0, 0);
    step(0, 1, 8'hA5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 8'h55, 0, 0, 0);
    step(0, 0, 8'h55, 0, 0, 0);
    step(0, 0, 8'h55, 0, 0, 0);
    step(0, 1, 8'h3C, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'hEE, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 8'hFF, 0, 1, 8'h40);
    step(0, 1, 8'h11, 0, 0, 0);
    step(0, 0, 0, 1, 1, 8'hFF);
    step(0, 1, 8'h77, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 8'h12, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 1, 8'h5A, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) < 6,
           8'($urandom),
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 9) == 0,
           ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
    end
    repeat (3) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
